// File: rtl/z3_dma_master.sv
// ---------------------------------------------------------------------------
// z3_dma_master
//
// Zorro III bus-master sequencer for the NCR 53C710 DMA path. It requests
// the Zorro III bus when the 710 asks for it, hands the grant on to the 710,
// and turns each 710 bus cycle into one Zorro III master cycle. Each cycle
// ends with STERM_n (normal completion) or SCSI_BERR_n (Zorro bus error or
// no DTACK within TIMEOUT+1 clocks). BMASTER tells the slave-side decoder
// and the buffer control that this card owns the bus.
//
// Ports
//   CLK, RESET        design clock (rising edge); synchronous active-high reset
//   SBR / SBG         710 bus request (async) / bus grant to the 710
//   BR_n / BG_n       Zorro bus request / Zorro bus grant (async)
//   BMASTER           high while this card owns the Zorro bus
//   SCSI_AS_n         710 address strobe (only looked at while we own the bus)
//   SCSI_READ         710 direction, 1 = read
//   SCSI_SIZ, SCSI_A  710 transfer size and address bits [1:0]
//   LOCK              710 locked-cycle request; keeps ownership between cycles
//   FCS_n, DS_n       Zorro full cycle strobe and byte data strobes
//                     (DS_n[3] is byte offset 0, on D[31:24])
//   DOE, READ         Zorro data output enable and direction
//   ADDR_OE           drives the 710 address onto the Zorro bus
//   DTACK_n, BERR_n   Zorro target acknowledge / bus error (async)
//   STERM_n           one-clock synchronous termination to the 710
//   SCSI_BERR_n       one-clock bus-error termination to the 710
// ---------------------------------------------------------------------------
module z3_dma_master #(
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SBR,
    output logic       SBG,
    output logic       BR_n,
    input  logic       BG_n,
    output logic       BMASTER,
    input  logic       SCSI_AS_n,
    input  logic       SCSI_READ,
    input  logic [1:0] SCSI_SIZ,
    input  logic [1:0] SCSI_A,
    input  logic       LOCK,
    output logic       FCS_n,
    output logic [3:0] DS_n,
    output logic       DOE,
    output logic       READ,
    output logic       ADDR_OE,
    input  logic       DTACK_n,
    input  logic       BERR_n,
    output logic       STERM_n,
    output logic       SCSI_BERR_n
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_OWN     = 3'd2,
        ST_ADDR    = 3'd3,
        ST_DATA    = 3'd4,
        ST_TERM    = 3'd5,
        ST_FAULT   = 3'd6,
        ST_RELEASE = 3'd7
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    // Idle level of the synchronized bundle {SBR, BG_n, DTACK_n, BERR_n}:
    // no request, no grant, no acknowledge, no error.
    localparam logic [3:0] SYNC_IDLE_C = 4'b0111;

    // Lane mask for a transfer of the given size starting at byte offset
    // offs. Lanes past byte 3 are dropped, so a long at offset 2 only
    // strobes bytes 2 and 3. Active-low, DS_n[3] is byte 0.
    function automatic logic [3:0] lane_mask(input logic [1:0] siz,
                                             input logic [1:0] offs);
        logic [2:0] last;
        logic [3:0] ds_n;
        case (siz)
            2'b01:   last = {1'b0, offs};
            2'b10:   last = {1'b0, offs} + 3'd1;
            2'b11:   last = {1'b0, offs} + 3'd2;
            2'b00:   last = {1'b0, offs} + 3'd3;
            default: last = {1'b0, offs} + 3'd3;
        endcase
        ds_n[3] = !(offs == 2'd0);
        ds_n[2] = !((offs <= 2'd1) && (last >= 3'd1));
        ds_n[1] = !((offs <= 2'd2) && (last >= 3'd2));
        ds_n[0] = !(last >= 3'd3);
        return ds_n;
    endfunction

    logic [3:0] async_in_s;
    logic [3:0] sync_r [SYNC_STAGES];
    logic       sbr_sync_s;
    logic       bg_n_sync_s;
    logic       dtack_n_sync_s;
    logic       berr_n_sync_s;
    logic [3:0] lane_mask_s;

    state_t     state_r;
    logic       sbg_r;
    logic       br_n_r;
    logic       bmaster_r;
    logic       fcs_n_r;
    logic [3:0] ds_n_r;
    logic       doe_r;
    logic       read_r;
    logic       addr_oe_r;
    logic       sterm_n_r;
    logic       scsi_berr_n_r;
    logic [1:0] siz_r;
    logic [1:0] offs_r;
    logic [7:0] cnt_r;

    assign async_in_s     = {SBR, BG_n, DTACK_n, BERR_n};
    assign sbr_sync_s     = sync_r[SYNC_STAGES-1][3];
    assign bg_n_sync_s    = sync_r[SYNC_STAGES-1][2];
    assign dtack_n_sync_s = sync_r[SYNC_STAGES-1][1];
    assign berr_n_sync_s  = sync_r[SYNC_STAGES-1][0];

    // Synchronizer chain for all asynchronous inputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= SYNC_IDLE_C;
            end
        end else begin
            sync_r[0] <= async_in_s;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Lane mask of the cycle latched at address strobe.
    always_comb begin
        lane_mask_s = lane_mask(siz_r, offs_r);
    end

    // Arbitration and master-cycle sequencer; every output is a register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r       <= ST_IDLE;
            sbg_r         <= 1'b0;
            br_n_r        <= 1'b1;
            bmaster_r     <= 1'b0;
            fcs_n_r       <= 1'b1;
            ds_n_r        <= 4'hF;
            doe_r         <= 1'b0;
            read_r        <= 1'b1;
            addr_oe_r     <= 1'b0;
            sterm_n_r     <= 1'b1;
            scsi_berr_n_r <= 1'b1;
            siz_r         <= 2'b00;
            offs_r        <= 2'b00;
            cnt_r         <= 8'd0;
        end else begin
            // Terminations are single-clock pulses; TERM/FAULT override.
            sterm_n_r     <= 1'b1;
            scsi_berr_n_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (sbr_sync_s) begin
                        br_n_r  <= 1'b0;
                        state_r <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // A grant that arrives with a withdrawn request is still
                    // taken; OWN then releases it cleanly.
                    if (!bg_n_sync_s) begin
                        bmaster_r <= 1'b1;
                        sbg_r     <= 1'b1;
                        br_n_r    <= 1'b1;
                        state_r   <= ST_OWN;
                    end else if (!sbr_sync_s) begin
                        br_n_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_OWN: begin
                    if (!SCSI_AS_n && bmaster_r) begin
                        read_r    <= SCSI_READ;
                        siz_r     <= SCSI_SIZ;
                        offs_r    <= SCSI_A;
                        addr_oe_r <= 1'b1;
                        state_r   <= ST_ADDR;
                    end else if (!sbr_sync_s && !LOCK) begin
                        state_r <= ST_RELEASE;
                    end else begin
                        state_r <= ST_OWN;
                    end
                end
                ST_ADDR: begin
                    fcs_n_r <= 1'b0;
                    state_r <= ST_DATA;
                end
                ST_DATA: begin
                    doe_r  <= 1'b1;
                    ds_n_r <= lane_mask_s;
                    cnt_r  <= cnt_r + 8'd1;
                    // Bus error outranks an acknowledge seen on the same clock.
                    if (!berr_n_sync_s || (cnt_r == TIMEOUT_C)) begin
                        state_r <= ST_FAULT;
                    end else if (!dtack_n_sync_s) begin
                        state_r <= ST_TERM;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_TERM: begin
                    sterm_n_r <= 1'b0;
                    fcs_n_r   <= 1'b1;
                    ds_n_r    <= 4'hF;
                    doe_r     <= 1'b0;
                    addr_oe_r <= 1'b0;
                    cnt_r     <= 8'd0;
                    state_r   <= ST_OWN;
                end
                ST_FAULT: begin
                    scsi_berr_n_r <= 1'b0;
                    fcs_n_r       <= 1'b1;
                    ds_n_r        <= 4'hF;
                    doe_r         <= 1'b0;
                    addr_oe_r     <= 1'b0;
                    cnt_r         <= 8'd0;
                    state_r       <= ST_OWN;
                end
                ST_RELEASE: begin
                    sbg_r     <= 1'b0;
                    bmaster_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign SBG         = sbg_r;
    assign BR_n        = br_n_r;
    assign BMASTER     = bmaster_r;
    assign FCS_n       = fcs_n_r;
    assign DS_n        = ds_n_r;
    assign DOE         = doe_r;
    assign READ        = read_r;
    assign ADDR_OE     = addr_oe_r;
    assign STERM_n     = sterm_n_r;
    assign SCSI_BERR_n = scsi_berr_n_r;

endmodule

// File: tb/tb_z3_dma_master.sv
// ---------------------------------------------------------------------------
// tb_z3_dma_master
//
// Directed bench for z3_dma_master (TIMEOUT=8, SYNC_STAGES=2). Each bus
// cycle pushes its hand-computed termination kind, lane mask and direction
// into a queue; a monitor pops and compares whenever the DUT terminates a
// cycle. Arbitration, cycle timing and reset behaviour are checked inline.
// ---------------------------------------------------------------------------
module tb_z3_dma_master;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       SBR;
    logic       SBG;
    logic       BR_n;
    logic       BG_n;
    logic       BMASTER;
    logic       SCSI_AS_n;
    logic       SCSI_READ;
    logic [1:0] SCSI_SIZ;
    logic [1:0] SCSI_A;
    logic       LOCK;
    logic       FCS_n;
    logic [3:0] DS_n;
    logic       DOE;
    logic       READ;
    logic       ADDR_OE;
    logic       DTACK_n;
    logic       BERR_n;
    logic       STERM_n;
    logic       SCSI_BERR_n;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       berr;
        logic [3:0] ds;
        logic       rd;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] cap_ds    = 4'hF;
    logic       pulse_chk = 1'b0;

    localparam logic [13:0] RESET_OUTS =
        {1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    z3_dma_master #(.TIMEOUT(8), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET(RESET), .SBR(SBR), .SBG(SBG), .BR_n(BR_n),
        .BG_n(BG_n), .BMASTER(BMASTER), .SCSI_AS_n(SCSI_AS_n),
        .SCSI_READ(SCSI_READ), .SCSI_SIZ(SCSI_SIZ), .SCSI_A(SCSI_A),
        .LOCK(LOCK), .FCS_n(FCS_n), .DS_n(DS_n), .DOE(DOE), .READ(READ),
        .ADDR_OE(ADDR_OE), .DTACK_n(DTACK_n), .BERR_n(BERR_n),
        .STERM_n(STERM_n), .SCSI_BERR_n(SCSI_BERR_n)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [13:0] outs();
        return {SBG, BR_n, BMASTER, FCS_n, DS_n, DOE, READ, ADDR_OE,
                STERM_n, SCSI_BERR_n};
    endfunction

    // Monitor: pops the scoreboard on every termination pulse.
    always @(negedge CLK) begin
        if (RESET) begin
            cap_ds    <= 4'hF;
            pulse_chk <= 1'b0;
        end else begin
            if (DOE) cap_ds <= DS_n;
            if (FCS_n) chk("ds_idle_with_fcs_high", 32'(DS_n), 32'(4'hF));
            if (pulse_chk) begin
                chk("term_width", 32'({STERM_n, SCSI_BERR_n}), 32'(2'b11));
                pulse_chk <= 1'b0;
            end else if (!STERM_n || !SCSI_BERR_n) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_term actual=%b%b required=none",
                             STERM_n, SCSI_BERR_n);
                end else begin
                    chk("term_kind", 32'({STERM_n, SCSI_BERR_n}),
                        32'(exp_q[0].berr ? 2'b10 : 2'b01));
                    chk("lane_ds", 32'(cap_ds), 32'(exp_q[0].ds));
                    chk("read_dir", 32'(READ), 32'(exp_q[0].rd));
                    void'(exp_q.pop_front());
                end
                pulse_chk <= 1'b1;
                cap_ds    <= 4'hF;
            end
        end
    end

    // One 710 cycle from OWN. d = DATA clock on which DTACK_n (and BERR_n
    // when both=1) is driven low, d<0 never. exp_lat counts negedges from
    // the first DATA clock to the termination pulse.
    task automatic bus_cycle(input string tag, input logic rd,
                             input logic [1:0] siz, input logic [1:0] a,
                             input logic [3:0] exp_ds, input int d,
                             input logic both, input logic exp_berr,
                             input int exp_lat);
        exp_t e;
        int   lat;
        e.berr = exp_berr;
        e.ds   = exp_ds;
        e.rd   = rd;
        exp_q.push_back(e);
        SCSI_AS_n = 1'b0;
        SCSI_READ = rd;
        SCSI_SIZ  = siz;
        SCSI_A    = a;
        @(negedge CLK);
        chk({tag, "_addr_oe"}, 32'({ADDR_OE, FCS_n}), 32'(2'b11));
        SCSI_AS_n = 1'b1;
        @(negedge CLK);
        chk({tag, "_fcs"}, 32'({FCS_n, DOE}), 32'(2'b00));
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (i == 1) chk({tag, "_data"}, 32'({DOE, DS_n}), 32'({1'b1, exp_ds}));
            if (!STERM_n || !SCSI_BERR_n) begin
                lat = i;
                break;
            end
            if (i == d) begin
                DTACK_n = 1'b0;
                if (both) BERR_n = 1'b0;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_cnt_clear"}, 32'(dut.cnt_r), 32'(8'd0));
        DTACK_n = 1'b1;
        BERR_n  = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        SBR       = 1'b0;
        BG_n      = 1'b1;
        SCSI_AS_n = 1'b1;
        SCSI_READ = 1'b1;
        SCSI_SIZ  = 2'b00;
        SCSI_A    = 2'b00;
        LOCK      = 1'b0;
        DTACK_n   = 1'b1;
        BERR_n    = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", 32'(outs()), 32'(RESET_OUTS));
        chk("reset_cnt", 32'(dut.cnt_r), 32'(8'd0));
        RESET = 1'b0;
        @(negedge CLK);

        // Arbitration: BR_n after 3 clocks, grant 3 clocks after BG_n falls.
        SBR = 1'b1;
        repeat (2) @(negedge CLK);
        chk("br_early", 32'(BR_n), 32'(1'b1));
        @(negedge CLK);
        chk("br_latency", 32'(BR_n), 32'(1'b0));
        repeat (10) @(negedge CLK);
        chk("wait_grant", 32'({BR_n, SBG, BMASTER}), 32'(3'b000));
        BG_n = 1'b0;
        repeat (2) @(negedge CLK);
        chk("sbg_early", 32'({SBG, BMASTER}), 32'(2'b00));
        @(negedge CLK);
        chk("grant", 32'({SBG, BMASTER, BR_n}), 32'(3'b111));

        // Bus cycles: lanes, truncation, direction, timeout, BERR priority.
        bus_cycle("rd_a1_byte", 1'b1, 2'b01, 2'd1, 4'b1011, 5, 1'b0, 1'b0, 9);
        bus_cycle("long_a2",    1'b1, 2'b00, 2'd2, 4'b1100, 1, 1'b0, 1'b0, 5);
        bus_cycle("tri_a3",     1'b0, 2'b11, 2'd3, 4'b1110, 2, 1'b0, 1'b0, 6);
        bus_cycle("long_a0",    1'b1, 2'b00, 2'd0, 4'b0000, 1, 1'b0, 1'b0, 5);
        bus_cycle("word_a0_wr", 1'b0, 2'b10, 2'd0, 4'b0011, 3, 1'b0, 1'b0, 7);
        bus_cycle("timeout",    1'b1, 2'b10, 2'd2, 4'b1100, -1, 1'b0, 1'b1, 10);
        bus_cycle("berr_dtack", 1'b1, 2'b01, 2'd0, 4'b0111, 1, 1'b1, 1'b1, 5);

        // Locked back-to-back cycles while SBR drops.
        LOCK = 1'b1;
        SBR  = 1'b0;
        bus_cycle("lock1", 1'b1, 2'b01, 2'd3, 4'b1110, 1, 1'b0, 1'b0, 5);
        bus_cycle("lock2", 1'b0, 2'b00, 2'd1, 4'b1000, 2, 1'b0, 1'b0, 6);
        repeat (3) @(negedge CLK);
        chk("lock_hold", 32'({SBG, BMASTER}), 32'(2'b11));
        LOCK = 1'b0;
        @(negedge CLK);
        chk("release_wait", 32'({SBG, BMASTER}), 32'(2'b11));
        @(negedge CLK);
        chk("released", 32'({SBG, BMASTER, BR_n}), 32'(3'b001));
        BG_n = 1'b1;

        // Re-arbitrate, then reset in the middle of DATA.
        @(negedge CLK);
        SBR = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rearb_br", 32'(BR_n), 32'(1'b0));
        BG_n = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rearb_grant", 32'(BMASTER), 32'(1'b1));
        SCSI_AS_n = 1'b0;
        SCSI_READ = 1'b1;
        SCSI_SIZ  = 2'b00;
        SCSI_A    = 2'd0;
        @(negedge CLK);
        SCSI_AS_n = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_pre_ds", 32'({FCS_n, DS_n}), 32'({1'b0, 4'b0000}));
        RESET = 1'b1;
        @(negedge CLK);
        chk("rst_mid_cycle", 32'(outs()), 32'(RESET_OUTS));
        chk("rst_state_idle", 32'(dut.state_r), 32'(3'd0));
        SBR  = 1'b0;
        BG_n = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        chk("after_rst_quiet", 32'({STERM_n, SCSI_BERR_n, BMASTER}), 32'(3'b110));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/z3_dma_master.md
# z3_dma_master

Zorro III bus-master sequencer for the NCR 53C710 DMA path. It arbitrates for the Zorro III bus on behalf of the SCSI chip and converts each 710 bus cycle into one Zorro III master cycle. It returns termination (STERM_n or bus error) to the 710. It sits directly upstream of the slave-side cycle decoder and buffer control, and drives the MASTER/BMASTER path that those blocks use to suppress slave decoding and to turn the buffers around.

## Interface
Parameters:
- TIMEOUT, 255, clocks spent in DATA without DTACK before a bus error is returned (8-bit counter).
- SYNC_STAGES, 2, synchronizer depth for SBR, BG_n, DTACK_n and BERR_n.

Ports:
- CLK  in  1  design clock; all logic rising-edge.
- RESET  in  1  synchronous, active-high reset.
- SBR  in  1  710 bus request, active high, asynchronous.
- SBG  out  1  bus grant to the 710, active high.
- BR_n  out  1  Zorro bus request.
- BG_n  in  1  Zorro bus grant, asynchronous.
- BMASTER  out  1  high while this card owns the bus.
- SCSI_AS_n  in  1  710 address strobe, sampled only while BMASTER is high.
- SCSI_READ  in  1  710 direction; 1 = read.
- SCSI_SIZ  in  2  710 size: 01 = byte, 10 = word, 11 = 3-byte, 00 = long.
- SCSI_A  in  2  710 address bits [1:0].
- LOCK  in  1  710 locked-cycle request; holds ownership across cycles.
- FCS_n  out  1  Zorro full cycle strobe.
- DS_n  out  4  Zorro data strobes; DS_n[3] = D[31:24] = byte offset 0.
- DOE  out  1  Zorro data output enable.
- READ  out  1  Zorro direction, copied from SCSI_READ.
- ADDR_OE  out  1  enables the 710 address onto the Zorro bus.
- DTACK_n  in  1  Zorro target acknowledge, asynchronous.
- BERR_n  in  1  Zorro bus error, asynchronous.
- STERM_n  out  1  synchronous termination to the 710.
- SCSI_BERR_n  out  1  bus-error termination to the 710.

## Operation
- Reset values: SBG=0, BR_n=1, BMASTER=0, FCS_n=1, DS_n=4'hF, DOE=0, READ=1, ADDR_OE=0, STERM_n=1, SCSI_BERR_n=1, timeout counter=0, state=IDLE.
- Every asynchronous input passes through a SYNC_STAGES flop chain, and decisions use only the synchronized value. SCSI_* inputs are synchronous to CLK.
- FSM states and transitions:
  - IDLE: if sync SBR=1, BR_n←0 and go to REQ.
  - REQ: if sync BG_n=0, BMASTER←1, SBG←1, BR_n←1 and go to OWN. If SBR drops before the grant, BR_n←1 and go to IDLE.
  - OWN:
    - If SCSI_AS_n=0, latch READ, SIZ and A[1:0], set ADDR_OE←1 and go to ADDR.
    - Otherwise, if sync SBR=0 and LOCK=0, go to RELEASE.
  - ADDR: one clock. FCS_n←0, then go to DATA.
  - DATA: DOE←1 and DS_n←lane mask. The counter increments each clock.
    - sync BERR_n=0, or counter==TIMEOUT: go to FAULT.
    - sync DTACK_n=0: go to TERM.
  - TERM: STERM_n←0 for exactly one clock. FCS_n, DS_n, DOE and ADDR_OE are deasserted, the counter clears, and the FSM goes to OWN.
  - FAULT: SCSI_BERR_n←0 for one clock. FCS_n, DS_n, DOE and ADDR_OE are deasserted, the counter clears, and the FSM goes to OWN.
  - RELEASE: SBG←0 and BMASTER←0, then go to IDLE.
- Lane mask: the asserted lanes cover bytes o through min(o+size−1, 3), where o=SCSI_A and size = 1/2/3/4 for SIZ 01/10/11/00. Lane for byte b is DS_n[3−b].
  - Example: o=1, byte → DS_n=4'b1011.
  - Example: o=2, long → DS_n=4'b1100 (truncated at 3).
- DS_n is held at 4'hF unless the state is DATA.
- LOCK=1 in OWN blocks RELEASE even when SBR=0. Ownership is released on the first OWN clock with LOCK=0 and SBR=0.
- BERR and DTACK seen in the same clock: BERR wins.
- SBR deasserted mid-cycle: the current cycle completes normally, and the release happens from OWN.
- RESET mid-cycle: all outputs return to reset values on the next edge. No termination is issued.

## Timing
- Grant latency: SBR rising to BR_n=0 takes SYNC_STAGES+1 clocks. BG_n=0 to SBG=1 takes SYNC_STAGES+1 clocks.
- Cycle: SCSI_AS_n sampled low at edge N gives ADDR_OE=1 after N, FCS_n=0 after N+1, and DS_n/DOE valid after N+2.
- Termination: DTACK_n low reaches sync at edge M, and STERM_n is low for exactly the clock after M+1. The minimum cycle is 4 clocks plus DTACK sync.
- Timeout: a bus error follows TIMEOUT+1 clocks in DATA.
- FCS_n never rises while DS_n is asserted. DS_n and FCS_n deassert on the same edge.

## Test plan
- Arbitration: raise SBR, hold BG_n=1 for 10 clocks, then drop BG_n → BR_n=0 after 3 clocks, SBG=1 and BMASTER=1 3 clocks after BG_n falls.
- Read cycle: AS_n low with A=1, SIZ=01, READ=1, DTACK after 5 clocks → FCS_n low, DS_n=4'b1011, exactly one STERM_n pulse, return to OWN.
- Lane truncation: A=2 with SIZ=00 → DS_n=4'b1100. A=3 with SIZ=11 → DS_n=4'b1110. A=0 with SIZ=00 → DS_n=4'b0000.
- Timeout: with TIMEOUT=8 and DTACK never asserted → SCSI_BERR_n pulses after 9 DATA clocks, no STERM_n, counter=0 afterwards.
- LOCK plus SBR drop: two back-to-back cycles with LOCK=1 while SBR falls → BMASTER stays 1 until LOCK=0, then SBG=0 and BMASTER=0 one clock later.
- RESET asserted in DATA → the next edge gives FCS_n=1, DS_n=4'hF, BR_n=1, BMASTER=0, state IDLE. Simultaneous BERR_n and DTACK_n → only SCSI_BERR_n pulses.
